page_fault_collector: RTL and testbench
=======================================

Name: page_fault_collector

Overview:
- Multi-channel, registered successor to the combinational page-fault examiner.
- Collects page faults from NCH pipeline channels (e.g. IF, MEM, AMO), holds each in a per-channel pending slot, and picks the oldest.
- Presents one ExceptStruct::ExceptPack to the CSR/trap unit and holds it stable until the trap is acknowledged.
- Keeps saturating per-cause fault counters for the perf CSRs. Sits between the MMU/pipeline and the CSR exception arbiter.

Parameters:
- NCH, 2, number of fault channels; index NCH-1 is the oldest pipeline stage.
- XLEN, 64, width of PC, epc, etval and ecause.
- VA_W, 39, virtual-address width (Sv39); vaddr is sign-extended from bit VA_W-1 to XLEN.
- TVAL_MODE, 1, 0 = etval forced to 0; 1 = etval = faulting vaddr.
- CNT_W, 16, width of each saturating fault counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- valid_i  in  NCH  channel carries a real instruction this cycle.
- pc_i  in  NCH*XLEN  PC per channel.
- vaddr_i  in  NCH*VA_W  faulting virtual address per channel.
- acc_i  in  NCH*2  access type: 00 none, 01 fetch, 10 load, 11 store/AMO.
- page_fault_i  in  NCH  MMU page-fault indication per channel.
- flush_i  in  NCH  squash of the instruction in channel i.
- trap_ack_i  in  1  CSR unit has taken the reported trap.
- except_o  out  ExceptPack  selected fault: except, epc, ecause, etval.
- stall_o  out  1  at least one slot pending; upstream must freeze.
- cnt_inst_o  out  CNT_W  instruction page faults captured.
- cnt_load_o  out  CNT_W  load page faults captured.
- cnt_store_o  out  CNT_W  store/AMO page faults captured.

Behaviour:
- Reset (rstn low, async): all slots empty; except_o all zero; stall_o=0; counters 0. Reset mid-handshake drops any pending fault.
- Per-slot FSM, two states:
  - EMPTY -> PEND when valid_i[i] & page_fault_i[i] & acc_i[i]!=00 & !flush_i[i]. Latch the following:
    - pc into epc.
    - cause: 01->`INST_PAGE_FAULT (12), 10->`LOAD_PAGE_FAULT (13), 11->`STORE_PAGE_FAULT (15).
    - tval: sign-extended vaddr if TVAL_MODE=1, else 0.
  - PEND ignores further capture on that channel; data stays stable.
  - PEND -> EMPTY on flush_i[i], on trap_ack_i when slot i is the winner, or on trap_ack_i when i is lower than the winner index (younger instructions are squashed).
  - Flush beats capture in the same cycle. Ack-squash beats a new capture on a younger channel in the same cycle.
- Selection: highest-index PEND slot wins; combinational from registered slots. Latency from fault input to except_o.except=1 is exactly 1 cycle.
- except_o is all-zero when no slot is pending.
- If an older channel captures while a younger one is being reported, except_o switches to the older fault on the next cycle. An ack is only valid for the fault currently shown.
- stall_o = OR of slot PEND bits.
- trap_ack_i with no pending slot: no effect.
- Counters increment once per EMPTY->PEND transition, by cause. Multiple channels capturing the same cause in one cycle add the count of captures. Counters saturate at all-ones and never wrap.

Decomposition:
- Shared package pf_pkg:
  - acc_t enum (NONE/FETCH/LOAD/STORE).
  - acc_to_cause function mapping onto the Define.vh cause macros.
  - pf_slot_t struct (pend, epc, ecause, etval).
- ExceptPack stays in ExceptStruct.
- One natural sub-module: pf_slot, the per-channel capture/clear FSM, instantiated NCH times by generate. Priority select, handshake and counters live in the top.

Test Plan:
- Reset then single fetch fault on ch0: pc=0x80000010, vaddr=0x4000001000 (bit 38 set) -> next cycle except=1, ecause=12, epc=0x80000010, etval=0xFFFFFFC000001000; stall_o=1; cnt_inst_o=1.
- Hold: no ack for 5 cycles while ch0 fault inputs are toggled -> except_o unchanged. Ack -> following cycle except=0, stall_o=0.
- Same-cycle faults: ch0 load and ch1 store (vaddr 0x2000) -> ch1 reported with ecause=15, etval=0x2000. Ack -> ch0 also cleared, except=0; cnt_load_o=1 and cnt_store_o=1.
- Flush vs capture: ch1 store fault with flush_i[1]=1 in the same cycle -> no capture, except stays 0, counters unchanged. Flush of a PEND slot -> cleared next cycle.
- TVAL_MODE=0 build, load fault at vaddr 0x1234 -> ecause=13, etval=0. acc_i=00 with page_fault_i=1 -> ignored.
- Counter saturation: CNT_W=4, 17 load faults each acked -> cnt_load_o=15. Async rstn pulse mid-pending -> except_o=0 immediately, counters 0.

Source files
------------

// File: rtl/ExceptStruct.sv
// rtl/ExceptStruct.sv - exception descriptor handed to the CSR/trap unit
// ExceptPack fields:
//   except : a trap is being reported
//   epc    : PC of the faulting instruction
//   ecause : mcause/scause value
//   etval  : trap value (faulting address or zero)
package ExceptStruct;

    typedef struct packed {
        logic        except;
        logic [63:0] epc;
        logic [63:0] ecause;
        logic [63:0] etval;
    } ExceptPack;

endpackage

// File: rtl/pf_pkg.sv
// rtl/pf_pkg.sv - shared types and cause mapping for the page fault collector
// Contents:
//   acc_t        : access type carried with each channel
//   slot_state_t : per-channel pending-slot state
//   pf_slot_t    : latched fault held by a slot
//   acc_to_cause : access type -> exception cause code
package pf_pkg;

    localparam int PF_XLEN = 64;

    localparam logic [PF_XLEN-1:0] INST_PAGE_FAULT  = PF_XLEN'(12);
    localparam logic [PF_XLEN-1:0] LOAD_PAGE_FAULT  = PF_XLEN'(13);
    localparam logic [PF_XLEN-1:0] STORE_PAGE_FAULT = PF_XLEN'(15);

    typedef enum logic [1:0] {
        ACC_NONE  = 2'b00,
        ACC_FETCH = 2'b01,
        ACC_LOAD  = 2'b10,
        ACC_STORE = 2'b11
    } acc_t;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_PEND  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic               pend;
        logic [PF_XLEN-1:0] epc;
        logic [PF_XLEN-1:0] ecause;
        logic [PF_XLEN-1:0] etval;
    } pf_slot_t;

    function automatic logic [PF_XLEN-1:0] acc_to_cause(input acc_t acc);
        case (acc)
            ACC_FETCH: return INST_PAGE_FAULT;
            ACC_LOAD:  return LOAD_PAGE_FAULT;
            ACC_STORE: return STORE_PAGE_FAULT;
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/pf_slot.sv
// rtl/pf_slot.sv - per-channel capture/clear FSM holding one pending page fault
// Ports:
//   clk, rstn   : clock, async active-low reset
//   valid       : channel carries a real instruction
//   page_fault  : MMU fault on this channel
//   acc         : access type (00 none, 01 fetch, 10 load, 11 store/AMO)
//   flush       : squash of this channel's instruction
//   ack_clr     : trap ack clears this slot (winner or younger than winner)
//   pc, vaddr   : instruction PC and faulting virtual address
//   slot        : registered slot contents
//   capture     : EMPTY->PEND transition happens at the next edge
module pf_slot
    import pf_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int VA_W      = 39,
    parameter int TVAL_MODE = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid,
    input  logic            page_fault,
    input  logic [1:0]      acc,
    input  logic            flush,
    input  logic            ack_clr,
    input  logic [XLEN-1:0] pc,
    input  logic [VA_W-1:0] vaddr,
    output pf_slot_t        slot,
    output logic            capture
);

    slot_state_t     state;
    logic [XLEN-1:0] tval;

    assign tval = (TVAL_MODE != 0) ? {{(XLEN-VA_W){vaddr[VA_W-1]}}, vaddr} : '0;

    // Flush and ack-squash both veto a capture in the same cycle.
    always_comb begin
        capture = (state == S_EMPTY) && valid && page_fault &&
                  (acc_t'(acc) != ACC_NONE) && !flush && !ack_clr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_EMPTY;
            slot  <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (capture) begin
                        state       <= S_PEND;
                        slot.pend   <= 1'b1;
                        slot.epc    <= pc;
                        slot.ecause <= acc_to_cause(acc_t'(acc));
                        slot.etval  <= tval;
                    end
                end
                S_PEND: begin
                    if (flush || ack_clr) begin
                        state <= S_EMPTY;
                        slot  <= '0;
                    end
                end
                default: begin
                    state <= S_EMPTY;
                    slot  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/page_fault_collector.sv
// rtl/page_fault_collector.sv - multi-channel page fault collector with oldest-first reporting
// Ports:
//   clk, rstn      : clock, async active-low reset
//   valid_i        : per-channel real instruction
//   pc_i, vaddr_i  : per-channel PC and faulting virtual address (flattened)
//   acc_i          : per-channel access type (flattened, 2 bits each)
//   page_fault_i   : per-channel MMU fault
//   flush_i        : per-channel squash
//   trap_ack_i     : CSR unit has taken the shown trap
//   except_o       : oldest pending fault, all-zero when none
//   stall_o        : any slot pending
//   cnt_*_o        : saturating per-cause capture counters
module page_fault_collector
    import pf_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int XLEN      = 64,
    parameter int VA_W      = 39,
    parameter int TVAL_MODE = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NCH-1:0]          valid_i,
    input  logic [NCH*XLEN-1:0]     pc_i,
    input  logic [NCH*VA_W-1:0]     vaddr_i,
    input  logic [NCH*2-1:0]        acc_i,
    input  logic [NCH-1:0]          page_fault_i,
    input  logic [NCH-1:0]          flush_i,
    input  logic                    trap_ack_i,
    output ExceptStruct::ExceptPack except_o,
    output logic                    stall_o,
    output logic [CNT_W-1:0]        cnt_inst_o,
    output logic [CNT_W-1:0]        cnt_load_o,
    output logic [CNT_W-1:0]        cnt_store_o
);

    localparam int WIN_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW    = $clog2(NCH + 1);

    pf_slot_t         slots [NCH];
    logic [NCH-1:0]   cap;
    logic [NCH-1:0]   ack_clr;
    logic [WIN_W-1:0] win_idx;
    logic             any_pend;
    logic [IW-1:0]    inc_inst, inc_load, inc_store;

    // Ascending scan: the last pending slot seen is the oldest.
    always_comb begin
        any_pend = 1'b0;
        win_idx  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (slots[i].pend) begin
                any_pend = 1'b1;
                win_idx  = WIN_W'(i);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_slot
            // Ack retires the winner and squashes every younger channel.
            assign ack_clr[g] = trap_ack_i && any_pend && (WIN_W'(g) <= win_idx);

            pf_slot #(
                .XLEN      (XLEN),
                .VA_W      (VA_W),
                .TVAL_MODE (TVAL_MODE)
            ) u_slot (
                .clk        (clk),
                .rstn       (rstn),
                .valid      (valid_i[g]),
                .page_fault (page_fault_i[g]),
                .acc        (acc_i[2*g +: 2]),
                .flush      (flush_i[g]),
                .ack_clr    (ack_clr[g]),
                .pc         (pc_i[XLEN*g +: XLEN]),
                .vaddr      (vaddr_i[VA_W*g +: VA_W]),
                .slot       (slots[g]),
                .capture    (cap[g])
            );
        end
    endgenerate

    always_comb begin
        except_o = '0;
        if (any_pend) begin
            except_o.except = 1'b1;
            except_o.epc    = slots[win_idx].epc;
            except_o.ecause = slots[win_idx].ecause;
            except_o.etval  = slots[win_idx].etval;
        end
    end

    assign stall_o = any_pend;

    always_comb begin
        inc_inst  = '0;
        inc_load  = '0;
        inc_store = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cap[i]) begin
                case (acc_t'(acc_i[2*i +: 2]))
                    ACC_FETCH: inc_inst  = inc_inst  + IW'(1);
                    ACC_LOAD:  inc_load  = inc_load  + IW'(1);
                    ACC_STORE: inc_store = inc_store + IW'(1);
                    default:   ;
                endcase
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [IW-1:0] n);
        logic [CNT_W+IW-1:0] s;
        s = {{IW{1'b0}}, c} + {{CNT_W{1'b0}}, n};
        return (|s[CNT_W+IW-1:CNT_W]) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_inst_o  <= '0;
            cnt_load_o  <= '0;
            cnt_store_o <= '0;
        end else begin
            cnt_inst_o  <= sat_add(cnt_inst_o,  inc_inst);
            cnt_load_o  <= sat_add(cnt_load_o,  inc_load);
            cnt_store_o <= sat_add(cnt_store_o, inc_store);
        end
    end

endmodule

// File: tb/tb_page_fault_collector.sv
// tb/tb_page_fault_collector.sv - directed self-checking bench for page_fault_collector
module tb_page_fault_collector;

    localparam int NCH  = 2;
    localparam int XLEN = 64;
    localparam int VA_W = 39;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NCH-1:0]      valid_i;
    logic [NCH*XLEN-1:0] pc_i;
    logic [NCH*VA_W-1:0] vaddr_i;
    logic [NCH*2-1:0]    acc_i;
    logic [NCH-1:0]      page_fault_i;
    logic [NCH-1:0]      flush_i;
    logic                trap_ack_i;

    ExceptStruct::ExceptPack exc, exc_t0, exc_sat;
    logic        stall, stall_t0, stall_sat;
    logic [15:0] ci, cl, cs;
    logic [15:0] ci_t0, cl_t0, cs_t0;
    logic [3:0]  ci_sat, cl_sat, cs_sat;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    page_fault_collector #(.NCH(NCH), .XLEN(XLEN), .VA_W(VA_W), .TVAL_MODE(1), .CNT_W(16)) u_dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .pc_i(pc_i), .vaddr_i(vaddr_i),
        .acc_i(acc_i), .page_fault_i(page_fault_i), .flush_i(flush_i), .trap_ack_i(trap_ack_i),
        .except_o(exc), .stall_o(stall), .cnt_inst_o(ci), .cnt_load_o(cl), .cnt_store_o(cs));

    page_fault_collector #(.NCH(NCH), .XLEN(XLEN), .VA_W(VA_W), .TVAL_MODE(0), .CNT_W(16)) u_t0 (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .pc_i(pc_i), .vaddr_i(vaddr_i),
        .acc_i(acc_i), .page_fault_i(page_fault_i), .flush_i(flush_i), .trap_ack_i(trap_ack_i),
        .except_o(exc_t0), .stall_o(stall_t0), .cnt_inst_o(ci_t0), .cnt_load_o(cl_t0), .cnt_store_o(cs_t0));

    page_fault_collector #(.NCH(NCH), .XLEN(XLEN), .VA_W(VA_W), .TVAL_MODE(1), .CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .pc_i(pc_i), .vaddr_i(vaddr_i),
        .acc_i(acc_i), .page_fault_i(page_fault_i), .flush_i(flush_i), .trap_ack_i(trap_ack_i),
        .except_o(exc_sat), .stall_o(stall_sat), .cnt_inst_o(ci_sat), .cnt_load_o(cl_sat), .cnt_store_o(cs_sat));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        valid_i      = '0;
        pc_i         = '0;
        vaddr_i      = '0;
        acc_i        = '0;
        page_fault_i = '0;
        flush_i      = '0;
        trap_ack_i   = 1'b0;
    endtask

    task automatic fault(input int ch, input logic [63:0] pc, input logic [38:0] va, input logic [1:0] acc);
        valid_i[ch]          = 1'b1;
        page_fault_i[ch]     = 1'b1;
        pc_i[ch*XLEN +: XLEN] = pc;
        vaddr_i[ch*VA_W +: VA_W] = va;
        acc_i[ch*2 +: 2]     = acc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_except", exc, '0);
        chk("rst_stall", stall, 0);
        chk("rst_counters", {ci, cl, cs}, '0);
        rstn = 1'b1;
        tick();

        // single fetch fault on ch0, vaddr bit 38 set
        fault(0, 64'h8000_0010, 39'h40_0000_1000, 2'b01);
        tick();
        clr_in();
        chk("f1_except", exc.except, 1);
        chk("f1_ecause", exc.ecause, 12);
        chk("f1_epc", exc.epc, 64'h8000_0010);
        chk("f1_etval", exc.etval, 64'hFFFF_FFC0_0000_1000);
        chk("f1_stall", stall, 1);
        chk("f1_cnt_inst", ci, 1);
        chk("f1_t0_etval", exc_t0.etval, 0);
        chk("f1_t0_ecause", exc_t0.ecause, 12);

        // hold while ch0 fault inputs toggle
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) fault(0, 64'h9000 + 64'(i), 39'h55, 2'b10);
            else clr_in();
            tick();
        end
        clr_in();
        chk("hold_epc", exc.epc, 64'h8000_0010);
        chk("hold_ecause", exc.ecause, 12);
        chk("hold_cnt_load", cl, 0);
        trap_ack_i = 1'b1;
        tick();
        clr_in();
        chk("ack1_except", exc, '0);
        chk("ack1_stall", stall, 0);

        // same-cycle faults: ch0 load, ch1 store
        fault(0, 64'h100, 39'h3000, 2'b10);
        fault(1, 64'h200, 39'h2000, 2'b11);
        tick();
        clr_in();
        chk("dual_epc", exc.epc, 64'h200);
        chk("dual_ecause", exc.ecause, 15);
        chk("dual_etval", exc.etval, 64'h2000);
        chk("dual_cnt_load", cl, 1);
        chk("dual_cnt_store", cs, 1);
        trap_ack_i = 1'b1;
        tick();
        clr_in();
        chk("dual_ack_except", exc, '0);
        chk("dual_ack_stall", stall, 0);

        // flush beats capture
        fault(1, 64'h210, 39'h2100, 2'b11);
        flush_i[1] = 1'b1;
        tick();
        clr_in();
        chk("flcap_except", exc, '0);
        chk("flcap_cnt_store", cs, 1);
        // flush of a pending slot
        fault(0, 64'h300, 39'h10, 2'b10);
        tick();
        clr_in();
        chk("flp_stall_set", stall, 1);
        chk("flp_cnt_load", cl, 2);
        flush_i[0] = 1'b1;
        tick();
        clr_in();
        chk("flp_stall_clr", stall, 0);
        chk("flp_except", exc, '0);

        // ack-squash beats a younger capture
        fault(1, 64'h400, 39'h40, 2'b01);
        tick();
        clr_in();
        chk("sq_epc", exc.epc, 64'h400);
        chk("sq_cnt_inst", ci, 2);
        trap_ack_i = 1'b1;
        fault(0, 64'h410, 39'h44, 2'b10);
        tick();
        clr_in();
        chk("sq_stall", stall, 0);
        chk("sq_cnt_load", cl, 2);

        // older channel overrides the shown younger fault
        fault(0, 64'h500, 39'h1234, 2'b10);
        tick();
        clr_in();
        chk("ov_epc0", exc.epc, 64'h500);
        chk("ov_ecause0", exc.ecause, 13);
        chk("ov_etval0", exc.etval, 64'h1234);
        chk("ov_t0_etval", exc_t0.etval, 0);
        chk("ov_t0_ecause", exc_t0.ecause, 13);
        fault(1, 64'h600, 39'h8, 2'b11);
        tick();
        clr_in();
        chk("ov_epc1", exc.epc, 64'h600);
        chk("ov_ecause1", exc.ecause, 15);
        chk("ov_cnt_store", cs, 2);
        trap_ack_i = 1'b1;
        tick();
        clr_in();
        chk("ov_ack_stall", stall, 0);

        // acc=00 ignored; ack with nothing pending has no effect
        fault(0, 64'h700, 39'h70, 2'b00);
        trap_ack_i = 1'b1;
        tick();
        clr_in();
        chk("none_stall", stall, 0);
        chk("none_except", exc, '0);
        chk("none_counters", {ci, cl, cs}, {16'd2, 16'd3, 16'd2});

        // counter saturation in the 4-bit build
        for (int i = 0; i < 17; i++) begin
            fault(0, 64'h1000 + 64'(i), 39'h100, 2'b10);
            tick();
            clr_in();
            trap_ack_i = 1'b1;
            tick();
            clr_in();
        end
        chk("sat_cnt_load4", cl_sat, 15);
        chk("sat_cnt_inst4", ci_sat, 2);
        chk("sat_cnt_load16", cl, 20);

        // async reset mid-pending
        fault(1, 64'h800, 39'h80, 2'b11);
        tick();
        clr_in();
        chk("ar_stall_pre", stall, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_except", exc, '0);
        chk("ar_stall", stall, 0);
        chk("ar_counters", {ci, cl, cs, 4'(0), cl_sat}, '0);
        #2;
        rstn = 1'b1;
        tick();
        chk("ar_after_except", exc, '0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
